round_countdown_ctrl: RTL and testbench

Parametrised countdown-and-result-display controller for timed game rounds: the successor to the fixed 7-LED speed-round controller. Sits between the master controller (which starts or aborts a round) and the LED bar. Runs a thermometer countdown on a slow tick enable and emits a one-cycle round-over pulse to the push counter. It then latches the round result and flashes the winner pattern a parametrised number of times on a fast tick enable, and signals exit back to the master controller. Adds abort, result latching and a busy flag.

---
 rtl/round_pkg.sv | 45 ++++
 rtl/rise_pulse.sv | 20 ++
 rtl/round_countdown_ctrl.sv | 113 +++++++++++
 tb/tb_round_countdown_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/round_pkg.sv
// Shared state encoding and LED pattern helpers for round_countdown_ctrl.
// Helpers work on a fixed 16-bit canvas; callers truncate to their bar width.
package round_pkg;

    localparam int MAX_LED_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_COUNT  = 3'd1,
        ST_EXPIRE = 3'd2,
        ST_SHOW   = 3'd3,
        ST_DARK   = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    // result_q encoding: {right_won, tie}; 2'b00 means the left player won
    localparam logic [1:0] RES_LEFT  = 2'b00;
    localparam logic [1:0] RES_TIE   = 2'b01;
    localparam logic [1:0] RES_RIGHT = 2'b10;

    function automatic int side_of(input int lw);
        return (lw - 1) / 2;
    endfunction

    function automatic logic [MAX_LED_W-1:0] thermometer(input logic [4:0] n);
        logic [MAX_LED_W:0] t;
        t = ({{MAX_LED_W{1'b0}}, 1'b1} << n) - 1'b1;
        return t[MAX_LED_W-1:0];
    endfunction

    function automatic logic [MAX_LED_W-1:0] pattern(input int lw, input logic [1:0] res);
        logic [MAX_LED_W-1:0] low_end;
        logic [MAX_LED_W-1:0] high_end;
        logic [MAX_LED_W-1:0] p;
        low_end  = thermometer(5'(side_of(lw)));
        high_end = low_end << (lw - side_of(lw));
        p = high_end;
        if (res[1])
            p = low_end;
        else if (res[0])
            p = low_end | high_end;
        return p;
    endfunction

endpackage

// File: rtl/rise_pulse.sv
// Registered-input rising-edge detector: one-cycle pulse on the first cycle a level is high.
module rise_pulse (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            level_q <= 1'b0;
        else
            level_q <= level;
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/round_countdown_ctrl.sv
// Round controller: thermometer countdown on tick, round-over pulse, then a latched
// winner pattern flashed on tick_fast before handing control back via exit.
module round_countdown_ctrl
    import round_pkg::*;
#(
    parameter int LED_W   = 7,
    parameter int FLASHES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             tick,
    input  logic             tick_fast,
    input  logic             result_right,
    input  logic             result_tie,
    output logic [LED_W-1:0] led,
    output logic             round_done,
    output logic             exit,
    output logic             busy
);

    localparam int STEP_W  = $clog2(LED_W + 1);
    localparam int FLASH_W = $clog2(FLASHES + 1);

    state_t             state;
    logic [STEP_W-1:0]  step_cnt;
    logic [FLASH_W-1:0] flash_cnt;
    logic [1:0]         result_q;
    logic               expire_lvl;

    // Abort outranks every enable; each state otherwise listens only to its own enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            step_cnt  <= '0;
            flash_cnt <= '0;
            result_q  <= RES_LEFT;
        end else if (abort) begin
            state     <= ST_IDLE;
            step_cnt  <= '0;
            flash_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_COUNT;
                        step_cnt  <= STEP_W'(LED_W);
                        flash_cnt <= '0;
                    end
                end
                ST_COUNT: begin
                    if (tick) begin
                        step_cnt <= step_cnt - 1'b1;
                        if (step_cnt == STEP_W'(1))
                            state <= ST_EXPIRE;
                    end
                end
                ST_EXPIRE: begin
                    if (tick) begin
                        state    <= ST_SHOW;
                        result_q <= {result_right, result_tie & ~result_right};
                    end
                end
                ST_SHOW: begin
                    if (tick_fast)
                        state <= ST_DARK;
                end
                ST_DARK: begin
                    if (tick_fast) begin
                        if (flash_cnt == FLASH_W'(FLASHES - 1)) begin
                            state <= ST_FINISH;
                        end else begin
                            flash_cnt <= flash_cnt + 1'b1;
                            state     <= ST_SHOW;
                        end
                    end
                end
                ST_FINISH: begin
                    if (tick)
                        state <= ST_IDLE;
                end
                default: begin
                    state     <= ST_IDLE;
                    step_cnt  <= '0;
                    flash_cnt <= '0;
                end
            endcase
        end
    end

    // Moore decode; unknown encodings fall through to a dark bar.
    always_comb begin
        led = '0;
        case (state)
            ST_COUNT: led = LED_W'(thermometer(5'(step_cnt)));
            ST_SHOW:  led = LED_W'(pattern(LED_W, result_q));
            default:  led = '0;
        endcase
    end

    assign exit       = (state == ST_FINISH);
    assign busy       = (state != ST_IDLE);
    assign expire_lvl = (state == ST_EXPIRE);

    rise_pulse u_done_pulse (
        .clk   (clk),
        .rst   (rst),
        .level (expire_lvl),
        .pulse (round_done)
    );

endmodule

// File: tb/tb_round_countdown_ctrl.sv
// Randomized self-checking bench: two configurations (7/4 and 10/1) share one stimulus bus.
module tb_round_countdown_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, abort = 1'b0, tick = 1'b0, tick_fast = 1'b0;
    logic result_right = 1'b0, result_tie = 1'b0;

    logic [6:0] led_a;
    logic [9:0] led_b;
    logic done_a, exit_a, busy_a, done_b, exit_b, busy_b;

    bit          sel = 1'b0;
    logic [18:0] obs;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    round_countdown_ctrl #(.LED_W(7), .FLASHES(4)) dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .tick(tick),
        .tick_fast(tick_fast), .result_right(result_right), .result_tie(result_tie),
        .led(led_a), .round_done(done_a), .exit(exit_a), .busy(busy_a)
    );

    round_countdown_ctrl #(.LED_W(10), .FLASHES(1)) dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .tick(tick),
        .tick_fast(tick_fast), .result_right(result_right), .result_tie(result_tie),
        .led(led_b), .round_done(done_b), .exit(exit_b), .busy(busy_b)
    );

    // Observed vector layout: {led[15:0], round_done, exit, busy}
    assign obs = sel ? {16'(led_b), done_b, exit_b, busy_b}
                     : {16'(led_a), done_a, exit_a, busy_a};

    function automatic logic [15:0] bar(input int n);
        return 16'((32'd1 << n) - 1);
    endfunction

    // Winner pattern straight from the rules: SIDE lit LEDs at the winner's end.
    function automatic logic [15:0] winner(input int w, input bit rr, input bit rt);
        int side;
        side = (w - 1) / 2;
        if (rr)      return bar(side);
        else if (rt) return bar(side) | (bar(side) << (w - side));
        else         return bar(side) << (w - side);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_round(input bit s, input bit rr, input bit rt, input bit hold);
        int w, f;
        logic [15:0] p;
        logic [18:0] exp;
        sel = s;
        w = s ? 10 : 7;
        f = s ? 1 : 4;
        p = winner(w, rr, rt);
        start = 1'b1;
        cyc();
        if (!hold) start = 1'b0;
        exp = {bar(w), 3'b001};
        checks++;
        if (obs !== exp) begin errors++; $display("[TB] FAIL count_entry got %h want %h", obs, exp); end
        for (int k = 1; k <= w; k++) begin
            repeat ($urandom_range(0, 2)) begin
                tick_fast = 1'($urandom);
                cyc();
                exp = {bar(w - k + 1), 3'b001};
                checks++;
                if (obs !== exp) begin errors++; $display("[TB] FAIL count_hold k=%0d got %h want %h", k, obs, exp); end
            end
            tick = 1'b1;
            tick_fast = 1'($urandom);
            cyc();
            tick = 1'b0;
            tick_fast = 1'b0;
            exp = (k < w) ? {bar(w - k), 3'b001} : {16'h0, 3'b101};
            checks++;
            if (obs !== exp) begin errors++; $display("[TB] FAIL count_tick k=%0d got %h want %h", k, obs, exp); end
        end
        repeat ($urandom_range(0, 2)) begin
            result_right = 1'($urandom);
            result_tie = 1'($urandom);
            tick_fast = 1'($urandom);
            cyc();
            exp = {16'h0, 3'b001};
            checks++;
            if (obs !== exp) begin errors++; $display("[TB] FAIL expire_wait got %h want %h", obs, exp); end
        end
        result_right = rr;
        result_tie = rt;
        tick = 1'b1;
        tick_fast = 1'($urandom);
        cyc();
        tick = 1'b0;
        tick_fast = 1'b0;
        result_right = ~rr;
        result_tie = 1'($urandom);
        exp = {p, 3'b001};
        checks++;
        if (obs !== exp) begin errors++; $display("[TB] FAIL show_entry got %h want %h", obs, exp); end
        for (int i = 0; i < f; i++) begin
            repeat ($urandom_range(0, 2)) begin
                tick = 1'($urandom);
                cyc();
                exp = {p, 3'b001};
                checks++;
                if (obs !== exp) begin errors++; $display("[TB] FAIL show_hold i=%0d got %h want %h", i, obs, exp); end
            end
            tick_fast = 1'b1;
            tick = 1'($urandom);
            cyc();
            tick_fast = 1'b0;
            tick = 1'b0;
            exp = {16'h0, 3'b001};
            checks++;
            if (obs !== exp) begin errors++; $display("[TB] FAIL dark i=%0d got %h want %h", i, obs, exp); end
            repeat ($urandom_range(0, 2)) begin
                tick = 1'($urandom);
                cyc();
                checks++;
                if (obs !== exp) begin errors++; $display("[TB] FAIL dark_hold i=%0d got %h want %h", i, obs, exp); end
            end
            tick = 1'b0;
            tick_fast = 1'b1;
            cyc();
            tick_fast = 1'b0;
            exp = (i < f - 1) ? {p, 3'b001} : {16'h0, 3'b011};
            checks++;
            if (obs !== exp) begin errors++; $display("[TB] FAIL flash_end i=%0d got %h want %h", i, obs, exp); end
        end
        repeat ($urandom_range(0, 2)) begin
            tick_fast = 1'($urandom);
            cyc();
            exp = {16'h0, 3'b011};
            checks++;
            if (obs !== exp) begin errors++; $display("[TB] FAIL finish_hold got %h want %h", obs, exp); end
        end
        tick_fast = 1'b0;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        exp = {16'h0, 3'b000};
        checks++;
        if (obs !== exp) begin errors++; $display("[TB] FAIL back_idle got %h want %h", obs, exp); end
        if (hold) begin
            cyc();
            start = 1'b0;
            exp = {bar(w), 3'b001};
            checks++;
            if (obs !== exp) begin errors++; $display("[TB] FAIL restart got %h want %h", obs, exp); end
        end
    endtask

    task automatic clear_all();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        checks++;
        if ({led_a, done_a, exit_a, busy_a, led_b, done_b, exit_b, busy_b} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got a=%h b=%h want 0", {led_a, done_a, exit_a, busy_a}, {led_b, done_b, exit_b, busy_b});
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_results();
        do_round(1'b0, 1'b1, 1'b0, 1'b0);
        do_round(1'b0, 1'b0, 1'b1, 1'b0);
        do_round(1'b0, 1'b1, 1'b1, 1'b0);
        do_round(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        sel = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        tick = 1'b1;
        repeat (6) cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        tick = 1'b0;
        checks++;
        if (obs !== 19'h0) begin errors++; $display("[TB] FAIL abort_edge got %h want 0", obs); end
        repeat (3) begin
            cyc();
            checks++;
            if (obs !== 19'h0) begin errors++; $display("[TB] FAIL abort_quiet got %h want 0", obs); end
        end
        do_round(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_wide();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        do_round(1'b1, 1'b1, 1'b0, 1'b0);
        do_round(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        sel = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        tick = 1'b1;
        repeat (8) cyc();
        tick = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 19'h0) begin errors++; $display("[TB] FAIL rst_in_show got %h want 0", obs); end
        #1 rst = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        tick = 1'b1;
        repeat (3) cyc();
        tick = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 19'h0) begin errors++; $display("[TB] FAIL rst_in_count got %h want 0", obs); end
        #1 rst = 1'b0;
        cyc();
        checks++;
        if (obs !== 19'h0) begin errors++; $display("[TB] FAIL rst_release got %h want 0", obs); end
    endtask

    task automatic test_start_held();
        do_round(1'b0, 1'b1, 1'b0, 1'b1);
        clear_all();
    endtask

    task automatic test_random_rounds();
        for (int r = 0; r < 6; r++) begin
            clear_all();
            do_round(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        clear_all();
    endtask

    initial begin
        test_reset();
        test_results();
        test_abort();
        test_async_reset();
        test_start_held();
        test_wide();
        test_random_rounds();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
